epp_bus_if: RTL and testbench

Host-side front end for the EPP link. Synchronizes the raw Digilent EPP pins (address strobe, data strobe, write, wait), runs the EPP handshake, and presents clean, clock-domain-internal level signals to the BRAM communication controller downstream. Those signals are `epp_addr`, `epp_wdata`, `stb_data` and `ctrl_wr`. Read data returned by the controller (`epp_rdata`) is captured and driven back onto the host bus.

---
 rtl/epp_pkg.sv | 23 ++
 rtl/epp_sync2.sv | 24 ++
 rtl/epp_bus_if.sv | 183 ++++++++++++++++++
 tb/tb_epp_bus_if.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/epp_pkg.sv
// Shared definitions for the EPP host front end: FSM encoding, parameter defaults,
// and the controller's register map.
package epp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AWR  = 3'd1,
    ST_ARD  = 3'd2,
    ST_DWR  = 3'd3,
    ST_DRD  = 3'd4,
    ST_ACK  = 3'd5
  } state_t;

  localparam int HOLD_CYC_DEF    = 4;
  localparam int RD_LAT_DEF      = 3;
  localparam int TIMEOUT_CYC_DEF = 1024;

  // Controller register addresses as seen through epp_addr.
  localparam logic [7:0] REG_DATA   = 8'h00;
  localparam logic [7:0] REG_PTR_LO = 8'h40;
  localparam logic [7:0] REG_PTR_HI = 8'h80;

endpackage

// File: rtl/epp_sync2.sv
// Two-flop synchronizer for one asynchronous pin; 2 clk latency, reset to RST_VAL.
// No handshake: the output simply follows the pin two cycles late.
module epp_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/epp_bus_if.sv
// EPP host handshake engine; strobe fall to FSM action 3 clk, every output registered.
// The host is held off by pwait; define EPP_TIMEOUT_EN to add the ACK watchdog.
module epp_bus_if
  import epp_pkg::*;
#(
  parameter int HOLD_CYC    = HOLD_CYC_DEF,
  parameter int RD_LAT      = RD_LAT_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       astb_n,
  input  logic       dstb_n,
  input  logic       pwr_n,
  input  logic [7:0] db_in,
  output logic [7:0] db_out,
  output logic       db_oe,
  output logic       pwait,
  output logic [7:0] epp_addr,
  output logic [7:0] epp_wdata,
  input  logic [7:0] epp_rdata,
  output logic       stb_data,
  output logic       ctrl_wr,
  output logic       busy,
  output logic       timeout_err
);

  logic astb_s, dstb_s, pwr_s;

  epp_sync2 #(.RST_VAL(1'b1)) u_sync_astb (.clk(clk), .rst_n(rst_n), .d(astb_n), .q(astb_s));
  epp_sync2 #(.RST_VAL(1'b1)) u_sync_dstb (.clk(clk), .rst_n(rst_n), .d(dstb_n), .q(dstb_s));
  epp_sync2 #(.RST_VAL(1'b1)) u_sync_pwr  (.clk(clk), .rst_n(rst_n), .d(pwr_n),  .q(pwr_s));

  state_t     state, state_d;
  logic [3:0] cnt, cnt_d;
  logic [7:0] addr_d, wdata_d, dout_d;
  logic       oe_d, pwait_d, stb_d, wr_d, busy_d;
  logic       to_hit;

`ifdef EPP_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt;
  logic            to_err;

  assign to_hit      = (state == ST_ACK) && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign timeout_err = to_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
      to_err <= 1'b0;
    end else begin
      if (state != ST_ACK || to_hit) to_cnt <= '0;
      else                           to_cnt <= to_cnt + 1'b1;
      if (to_hit) to_err <= 1'b1;
    end
  end
`else
  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      db_out    <= 8'h00;
      db_oe     <= 1'b0;
      pwait     <= 1'b0;
      epp_addr  <= 8'h00;
      epp_wdata <= 8'h00;
      stb_data  <= 1'b1;
      ctrl_wr   <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      db_out    <= dout_d;
      db_oe     <= oe_d;
      pwait     <= pwait_d;
      epp_addr  <= addr_d;
      epp_wdata <= wdata_d;
      stb_data  <= stb_d;
      ctrl_wr   <= wr_d;
      busy      <= busy_d;
    end
  end

  // Data is latched on the decision edge so it leads the strobes by one cycle;
  // the counter then runs to zero with the strobes held, and the zero cycle releases them.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    addr_d  = epp_addr;
    wdata_d = epp_wdata;
    dout_d  = db_out;
    oe_d    = db_oe;
    pwait_d = pwait;
    stb_d   = stb_data;
    wr_d    = ctrl_wr;

    unique case (state)
      ST_IDLE: begin
        if (!astb_s) begin
          if (!pwr_s) begin
            state_d = ST_AWR;
            addr_d  = db_in;
            cnt_d   = 4'(HOLD_CYC);
          end else begin
            state_d = ST_ARD;
          end
        end else if (!dstb_s) begin
          if (!pwr_s) begin
            state_d = ST_DWR;
            wdata_d = db_in;
            cnt_d   = 4'(HOLD_CYC);
          end else begin
            state_d = ST_DRD;
            cnt_d   = 4'(RD_LAT);
          end
        end
      end
      ST_AWR: begin
        if (cnt == 4'd0) begin
          wr_d    = 1'b1;
          pwait_d = 1'b1;
          state_d = ST_ACK;
        end else begin
          wr_d  = 1'b0;
          cnt_d = cnt - 4'd1;
        end
      end
      ST_ARD: begin
        dout_d  = epp_addr;
        oe_d    = 1'b1;
        pwait_d = 1'b1;
        state_d = ST_ACK;
      end
      ST_DWR: begin
        if (cnt == 4'd0) begin
          wr_d    = 1'b1;
          stb_d   = 1'b1;
          pwait_d = 1'b1;
          state_d = ST_ACK;
        end else begin
          wr_d  = 1'b0;
          stb_d = 1'b0;
          cnt_d = cnt - 4'd1;
        end
      end
      ST_DRD: begin
        if (cnt == 4'd0) begin
          dout_d  = epp_rdata;
          oe_d    = 1'b1;
          stb_d   = 1'b1;
          pwait_d = 1'b1;
          state_d = ST_ACK;
        end else begin
          stb_d = 1'b0;
          wr_d  = 1'b1;
          cnt_d = cnt - 4'd1;
        end
      end
      ST_ACK: begin
        if (astb_s && dstb_s) begin
          pwait_d = 1'b0;
          oe_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (to_hit) begin
      state_d = ST_IDLE;
      pwait_d = 1'b0;
      oe_d    = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_epp_bus_if.sv
// Directed plus randomized host cycles against a timing model of the EPP handshake.
module tb_epp_bus_if;

  localparam int HOLD = 4;
  localparam int RDL  = 3;
  localparam int TO   = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       astb_n = 1'b1, dstb_n = 1'b1, pwr_n = 1'b1;
  logic [7:0] db_in = 8'h00, epp_rdata = 8'h00;
  logic [7:0] db_out, epp_addr, epp_wdata;
  logic       db_oe, pwait, stb_data, ctrl_wr, busy, timeout_err;

  int checks = 0;
  int errors = 0;
  logic [7:0] addr_m = 8'h00;
  logic [7:0] wdata_m = 8'h00;

  epp_bus_if #(.HOLD_CYC(HOLD), .RD_LAT(RDL), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .astb_n(astb_n), .dstb_n(dstb_n), .pwr_n(pwr_n),
    .db_in(db_in), .db_out(db_out), .db_oe(db_oe), .pwait(pwait),
    .epp_addr(epp_addr), .epp_wdata(epp_wdata), .epp_rdata(epp_rdata),
    .stb_data(stb_data), .ctrl_wr(ctrl_wr), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // kind: 0 address write, 1 address read, 2 data write, 3 data read.
  // Edge k is the k-th rising edge after the strobe pin falls.
  task automatic xfer(input int kind, input logic [7:0] d, input logic [7:0] rd,
                      input int extra, input bit early, input bit both);
    int lat, pw_at, rel_k, last_k;
    bit is_rd, wr_lo, stb_lo, pw_e;
    logic [7:0] exp_rd;
    is_rd = (kind == 1) || (kind == 3);
    lat   = (kind == 1) ? 0 : (kind == 3) ? RDL : HOLD;
    pw_at = 3 + lat + 1;
    if (kind == 0) addr_m  = d;
    if (kind == 2) wdata_m = d;
    exp_rd = (kind == 1) ? addr_m : rd;
    rel_k  = early ? 4 : pw_at + extra;
    last_k = early ? pw_at + 1 : rel_k + 3;

    @(negedge clk);
    pwr_n = is_rd; db_in = d; epp_rdata = rd;
    if (kind >= 2) dstb_n = 1'b0; else astb_n = 1'b0;
    if (both) dstb_n = 1'b0;

    for (int k = 1; k <= last_k; k++) begin
      @(posedge clk); #1;
      wr_lo  = (kind == 0 || kind == 2) && k >= 4 && k <= 3 + HOLD;
      stb_lo = (kind == 2 && k >= 4 && k <= 3 + HOLD) || (kind == 3 && k >= 4 && k <= 3 + RDL);
      pw_e   = early ? (k == pw_at) : (k >= pw_at && k < rel_k + 3);
      chk($sformatf("ctrl_wr k%0d kind%0d", k, kind), ctrl_wr, !wr_lo);
      chk($sformatf("stb_data k%0d kind%0d", k, kind), stb_data, !stb_lo);
      chk($sformatf("pwait k%0d kind%0d", k, kind), pwait, pw_e);
      chk($sformatf("busy k%0d kind%0d", k, kind), busy, (k >= 3 && k < last_k));
      chk($sformatf("db_oe k%0d kind%0d", k, kind), db_oe, is_rd && pw_e);
      if (is_rd && pw_e) chk($sformatf("db_out k%0d kind%0d", k, kind), db_out, exp_rd);
      if (k >= 3) begin
        chk($sformatf("epp_addr k%0d", k), epp_addr, addr_m);
        chk($sformatf("epp_wdata k%0d", k), epp_wdata, wdata_m);
      end
      chk("timeout_err idle", timeout_err, 1'b0);
      if (k == rel_k) begin
        @(negedge clk);
        astb_n = 1'b1; dstb_n = 1'b1;
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst db_out", db_out, 8'h00);
    chk("rst db_oe", db_oe, 1'b0);
    chk("rst pwait", pwait, 1'b0);
    chk("rst epp_addr", epp_addr, 8'h00);
    chk("rst epp_wdata", epp_wdata, 8'h00);
    chk("rst stb_data", stb_data, 1'b1);
    chk("rst ctrl_wr", ctrl_wr, 1'b1);
    chk("rst busy", busy, 1'b0);
    chk("rst timeout_err", timeout_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    xfer(0, 8'h40, 8'h00, 2, 1'b0, 1'b0);   // address write
    xfer(2, 8'hFF, 8'h00, 1, 1'b0, 1'b0);   // data write
    xfer(3, 8'h11, 8'h5A, 0, 1'b0, 1'b0);   // data read
    xfer(1, 8'h00, 8'h00, 3, 1'b0, 1'b0);   // address read returns 0x40
    xfer(0, 8'h80, 8'h00, 1, 1'b0, 1'b1);   // both strobes: address wins
    xfer(2, 8'h3C, 8'h00, 0, 1'b1, 1'b0);   // early release, write completes
    xfer(3, 8'h00, 8'hC3, 0, 1'b1, 1'b0);   // early release, read completes

    for (int i = 0; i < 16; i++)
      xfer(int'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
           int'($urandom_range(0, 3)), 1'b0, 1'b0);

    // Reset in the middle of a data write hold
    @(negedge clk);
    pwr_n = 1'b0; db_in = 8'hA5; dstb_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("pre-reset ctrl_wr", ctrl_wr, 1'b0);
    chk("pre-reset epp_wdata", epp_wdata, 8'hA5);
    #2;
    rst_n = 1'b0;
    #1;
    addr_m = 8'h00; wdata_m = 8'h00;
    chk("mid-rst stb_data", stb_data, 1'b1);
    chk("mid-rst ctrl_wr", ctrl_wr, 1'b1);
    chk("mid-rst pwait", pwait, 1'b0);
    chk("mid-rst busy", busy, 1'b0);
    chk("mid-rst epp_wdata", epp_wdata, wdata_m);
    chk("mid-rst epp_addr", epp_addr, addr_m);
    @(negedge clk);
    dstb_n = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    xfer(2, 8'h5C, 8'h00, 1, 1'b0, 1'b0);   // clean write after reset

`ifdef EPP_TIMEOUT_EN
    @(negedge clk);
    pwr_n = 1'b1; astb_n = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 19) begin
        chk("to pwait before limit", pwait, 1'b1);
        chk("to err before limit", timeout_err, 1'b0);
      end
      if (k == 20) begin
        chk("to pwait at limit", pwait, 1'b0);
        chk("to db_oe at limit", db_oe, 1'b0);
        chk("to err at limit", timeout_err, 1'b1);
      end
      if (k == 40) chk("to err sticky", timeout_err, 1'b1);
    end
    @(negedge clk);
    astb_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("to err after release", timeout_err, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("to err cleared by reset", timeout_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
`else
    chk("timeout_err tied low", timeout_err, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
